sparse_mac_scheduler: RTL and testbench
=======================================

# sparse_mac_scheduler

Job-level controller in front of `multiply_and_accum`. It accepts a dot-product job and merges two index-sorted sparse element streams, one from each decoder. Matched-index value pairs go to the MAC, and a per-job result comes back once the MAC pipeline has drained. The MAC accumulator has no clear, so each job result is taken relative to an accumulator snapshot captured at job start.

## Interface
Parameters:
- `NUM_DECODERS`, 2: number of input streams; any other value is an elaboration error.
- `LEN_W`, 16: width of the job length fields.
- `DRAIN_CYCLES`, 2: cycles from the last pair issue to a stable accumulator (MAC multiply stage plus accumulate stage).

Ports:
- `mac_clk`  in  1  sole clock.
- `mac_rst`  in  1  asynchronous, active-low reset.
- `job_valid_i`  in  1  job request.
- `job_ready_o`  out  1  high only in IDLE.
- `job_len_a_i`, `job_len_b_i`  in  LEN_W  element counts of stream A and stream B.
- `a_valid_i`, `b_valid_i`  in  1  stream head valid.
- `a_ready_o`, `b_ready_o`  out  1  pop the stream head.
- `a_data_i`, `b_data_i`  in  `sparse_elem_t`  {index, value}.
- `pair_valid_o`  out  1  to MAC `comparator_valid_i`.
- `pair_data_o`  out  `value_bus_t[NUM_DECODERS-1:0]`  to MAC `comparator_data_i`; [0]=A, [1]=B.
- `done_o`  out  1  to MAC `comparator_done_i`.
- `mac_data_i`  in  ACCUM_W  from MAC `mac_data_o`.
- `result_valid_o`  out  1  job result available.
- `result_ready_i`  in  1  result accepted.
- `result_data_o`  out  ACCUM_W  job dot product.

## Operation
- FSM states: IDLE, MERGE, FLUSH, DRAIN, RESULT.
- IDLE:
  - On `job_valid_i`, latch both lengths, clear the pop counters, and snapshot `base <= mac_data_i`.
  - Go to MERGE.
  - If either length is 0, go straight to FLUSH.
- MERGE, when both heads are valid:
  - Index equal: pop both and issue a pair.
  - A index < B index: pop A only.
  - Otherwise: pop B only.
  - No pop while either head is invalid.
  - Ready is combinational from valid and index; valid never depends on ready.
- When popped count A equals len A, or popped count B equals len B: go to FLUSH.
- FLUSH:
  - Pop the remaining elements of the unexhausted stream without issuing pairs, until both counts equal their lengths.
  - Then go to DRAIN.
- DRAIN:
  - Count DRAIN_CYCLES cycles.
  - In the last drain cycle, pulse `done_o` and register `result_data_o <= mac_data_i - base`, modulo 2^ACCUM_W.
  - Go to RESULT.
- RESULT: hold `result_valid_o` until `result_ready_i`, then go to IDLE.
- Streams carry strictly increasing indices per job. Duplicate or decreasing indices are not checked; the merge rules above still apply as written.

## Timing
- Reset values: `job_ready_o`=0 in reset and 1 from the first cycle after reset; all other outputs 0; state IDLE.
- `pair_valid_o` and `pair_data_o` are registered: a pop on edge N gives `pair_valid_o` high in cycle N+1 for exactly one cycle.
- Back-to-back matches give consecutive `pair_valid_o` cycles, i.e. one pair per cycle.
- The drain count starts in the cycle after the final `pair_valid_o`, so the result reflects all of the job's products.
- Job accept to first possible pop: 1 cycle.
- `done_o` is high for exactly one cycle per job, including zero-match and zero-length jobs.
- A simultaneous last pop of A and B goes directly from MERGE to DRAIN.
- A job request arriving during a busy job is not accepted; `job_ready_o` is 0 in that case.
- Reset mid-job returns to IDLE and discards partial state.
  - The MAC accumulator is also reset, so the next snapshot is 0.

## Configuration
- `SPARSE_MAC_SCHED_STATS_EN` defined:
  - Adds outputs `stat_matches_o` (LEN_W) and `stat_cycles_o` (32) for the last job.
  - Both are cleared at job accept and frozen at `done_o`.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

## Structure
- `sparse_mac_pkg` holds:
  - INDEX_W, VALUE_W, ACCUM_W.
  - `sparse_elem_t` {INDEX_W index; VALUE_W value}.
  - `value_bus_t`.
  - `sched_state_t` enum.
- Natural sub-module: `sparse_index_merge`. It is the combinational compare/pop decision for two heads and has no state.
- The FSM, counters and registers live in the top module.

## Test plan
- Basic match:
  - Stimulus: A idx {1,3,5} val {2,4,6}; B idx {3,5,7} val {10,1,9}.
  - Required: 2 pairs, (4,10) then (6,1); `done_o` once; `result_data_o`=46.
- Disjoint indices:
  - Stimulus: A {0,2}, B {1,3}.
  - Required: no `pair_valid_o`; result 0; all 4 elements popped.
- Zero length:
  - Stimulus: len A=0, len B=3.
  - Required: 3 B pops in FLUSH; `done_o` pulses; result 0.
- Base subtraction:
  - Stimulus: job 1 result 46, then job 2 with a single match 7×3.
  - Required: job 2 result 21 while the MAC accumulator reads 67.
- Result backpressure:
  - Stimulus: hold `result_ready_i`=0 for 5 cycles.
  - Required: `result_valid_o` and data stable; `job_ready_o`=0 until the handshake completes.
- Reset mid-MERGE:
  - Stimulus: deassert `mac_rst` after the first pair.
  - Required: all outputs return to reset values; the next job works from base 0.

Source files
------------

// File: rtl/sparse_mac_pkg.sv
// Shared types for the sparse MAC scheduler: element/value widths,
// the sparse stream element and the scheduler FSM encoding.
package sparse_mac_pkg;

  localparam int unsigned INDEX_W = 16;
  localparam int unsigned VALUE_W = 16;
  localparam int unsigned ACCUM_W = 32;

  typedef logic [VALUE_W-1:0] value_bus_t;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    value_bus_t         value;
  } sparse_elem_t;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    FLUSH,
    DRAIN,
    RESULT
  } sched_state_t;

endpackage

// File: rtl/sparse_index_merge.sv
// Stateless compare/pop decision for the heads of two index-sorted streams.
module sparse_index_merge
  import sparse_mac_pkg::*;
(
  input  logic               a_valid,
  input  logic               b_valid,
  input  logic [INDEX_W-1:0] a_index,
  input  logic [INDEX_W-1:0] b_index,
  output logic               pop_a,
  output logic               pop_b,
  output logic               match
);

  // Pop the smaller index; pop both and flag a match on equal indices
  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    match = 1'b0;
    if (a_valid && b_valid) begin
      if (a_index == b_index) begin
        pop_a = 1'b1;
        pop_b = 1'b1;
        match = 1'b1;
      end else if (a_index < b_index) begin
        pop_a = 1'b1;
      end else begin
        pop_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_mac_scheduler.sv
// Job-level controller in front of multiply_and_accum: merges two sparse
// streams, issues matched value pairs, waits for the MAC to drain and returns
// the job dot product relative to the accumulator snapshot taken at accept.
// Optional per-job statistics ports: define SPARSE_MAC_SCHED_STATS_EN.
module sparse_mac_scheduler
  import sparse_mac_pkg::*;
#(
  parameter int unsigned NUM_DECODERS = 2,
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                              mac_clk,
  input  logic                              mac_rst,
  input  logic                              job_valid_i,
  output logic                              job_ready_o,
  input  logic [LEN_W-1:0]                  job_len_a_i,
  input  logic [LEN_W-1:0]                  job_len_b_i,
  input  logic                              a_valid_i,
  input  logic                              b_valid_i,
  output logic                              a_ready_o,
  output logic                              b_ready_o,
  input  sparse_elem_t                      a_data_i,
  input  sparse_elem_t                      b_data_i,
  output logic                              pair_valid_o,
  output value_bus_t [NUM_DECODERS-1:0]     pair_data_o,
  output logic                              done_o,
  input  logic [ACCUM_W-1:0]                mac_data_i,
`ifdef SPARSE_MAC_SCHED_STATS_EN
  output logic [LEN_W-1:0]                  stat_matches_o,
  output logic [31:0]                       stat_cycles_o,
`endif
  output logic                              result_valid_o,
  input  logic                              result_ready_i,
  output logic [ACCUM_W-1:0]                result_data_o
);

  if (NUM_DECODERS != 2) begin : g_num_decoders_check
    $error("sparse_mac_scheduler supports exactly two decoder streams");
  end

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  sched_state_t                  state_q, state_d;
  logic [LEN_W-1:0]              len_a_q, len_b_q;
  logic [LEN_W-1:0]              cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
  logic [ACCUM_W-1:0]            base_q, result_q;
  logic [DRAIN_W-1:0]            drain_cnt_q;
  logic                          job_ready_q, pair_valid_q;
  value_bus_t [NUM_DECODERS-1:0] pair_data_q;
  logic                          m_pop_a, m_pop_b, m_match;
  logic                          pop_a, pop_b, issue, accept, drain_last;
  logic                          a_exhausted, b_exhausted;

  sparse_index_merge u_merge (
    .a_valid (a_valid_i),
    .b_valid (b_valid_i),
    .a_index (a_data_i.index),
    .b_index (b_data_i.index),
    .pop_a   (m_pop_a),
    .pop_b   (m_pop_b),
    .match   (m_match)
  );

  // State register
  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Pop decisions first, then transitions based on the post-pop counts
  always_comb begin
    state_d    = state_q;
    pop_a      = 1'b0;
    pop_b      = 1'b0;
    issue      = 1'b0;
    accept     = 1'b0;
    drain_last = 1'b0;
    case (state_q)
      MERGE: begin
        pop_a = m_pop_a;
        pop_b = m_pop_b;
        issue = m_match;
      end
      FLUSH: begin
        pop_a = a_valid_i && (cnt_a_q != len_a_q);
        pop_b = b_valid_i && (cnt_b_q != len_b_q);
      end
      default: ;
    endcase
    cnt_a_d     = cnt_a_q + LEN_W'(pop_a);
    cnt_b_d     = cnt_b_q + LEN_W'(pop_b);
    a_exhausted = (cnt_a_d == len_a_q);
    b_exhausted = (cnt_b_d == len_b_q);
    case (state_q)
      IDLE: begin
        if (job_valid_i && job_ready_q) begin
          accept  = 1'b1;
          state_d = (job_len_a_i == '0 || job_len_b_i == '0) ? FLUSH : MERGE;
        end
      end
      MERGE: begin
        if (a_exhausted && b_exhausted)      state_d = DRAIN;
        else if (a_exhausted || b_exhausted) state_d = FLUSH;
      end
      FLUSH: begin
        if (a_exhausted && b_exhausted) state_d = DRAIN;
      end
      DRAIN: begin
        // Counting only starts once the last issued pair has left the output
        if (!pair_valid_q && drain_cnt_q == DRAIN_LAST) begin
          drain_last = 1'b1;
          state_d    = RESULT;
        end
      end
      RESULT: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job registers, pop counters, pair output and result capture
  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      job_ready_q  <= 1'b0;
      len_a_q      <= '0;
      len_b_q      <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      base_q       <= '0;
      drain_cnt_q  <= '0;
      pair_valid_q <= 1'b0;
      pair_data_q  <= '0;
      result_q     <= '0;
    end else begin
      job_ready_q  <= (state_d == IDLE);
      pair_valid_q <= issue;
      if (issue) begin
        pair_data_q[0] <= a_data_i.value;
        pair_data_q[1] <= b_data_i.value;
      end
      if (accept) begin
        len_a_q <= job_len_a_i;
        len_b_q <= job_len_b_i;
        cnt_a_q <= '0;
        cnt_b_q <= '0;
        base_q  <= mac_data_i;
      end else begin
        cnt_a_q <= cnt_a_d;
        cnt_b_q <= cnt_b_d;
      end
      if (state_q == DRAIN && !pair_valid_q) drain_cnt_q <= drain_cnt_q + 1'b1;
      else                                    drain_cnt_q <= '0;
      if (drain_last) result_q <= mac_data_i - base_q;
    end
  end

  assign job_ready_o    = job_ready_q;
  assign a_ready_o      = pop_a;
  assign b_ready_o      = pop_b;
  assign pair_valid_o   = pair_valid_q;
  assign pair_data_o    = pair_data_q;
  assign done_o         = drain_last;
  assign result_valid_o = (state_q == RESULT);
  assign result_data_o  = result_q;

`ifdef SPARSE_MAC_SCHED_STATS_EN
  logic             stat_run_q;
  logic [LEN_W-1:0] stat_matches_q;
  logic [31:0]      stat_cycles_q;

  // Per-job counters: cleared on accept, frozen after the done cycle
  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      stat_run_q     <= 1'b0;
      stat_matches_q <= '0;
      stat_cycles_q  <= '0;
    end else if (accept) begin
      stat_run_q     <= 1'b1;
      stat_matches_q <= '0;
      stat_cycles_q  <= '0;
    end else if (stat_run_q) begin
      stat_cycles_q <= stat_cycles_q + 32'd1;
      if (issue)      stat_matches_q <= stat_matches_q + LEN_W'(1);
      if (drain_last) stat_run_q     <= 1'b0;
    end
  end

  assign stat_matches_o = stat_matches_q;
  assign stat_cycles_o  = stat_cycles_q;
`endif

endmodule

// File: tb/tb_sparse_mac_scheduler.sv
// Scoreboard bench for sparse_mac_scheduler with a two-stage MAC model.
module tb_sparse_mac_scheduler;
  import sparse_mac_pkg::*;

  logic               mac_clk, mac_rst;
  logic               job_valid_i, job_ready_o;
  logic [15:0]        job_len_a_i, job_len_b_i;
  logic               a_valid_i, b_valid_i, a_ready_o, b_ready_o;
  sparse_elem_t       a_data_i, b_data_i;
  logic               pair_valid_o, done_o;
  value_bus_t [1:0]   pair_data_o;
  logic [ACCUM_W-1:0] mac_data_i;
  logic               result_valid_o, result_ready_i;
  logic [ACCUM_W-1:0] result_data_o;
`ifdef SPARSE_MAC_SCHED_STATS_EN
  logic [15:0]        stat_matches_o;
  logic [31:0]        stat_cycles_o;
`endif

  sparse_mac_scheduler #(.NUM_DECODERS(2), .LEN_W(16), .DRAIN_CYCLES(2)) dut (
    .mac_clk        (mac_clk),
    .mac_rst        (mac_rst),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_len_a_i    (job_len_a_i),
    .job_len_b_i    (job_len_b_i),
    .a_valid_i      (a_valid_i),
    .b_valid_i      (b_valid_i),
    .a_ready_o      (a_ready_o),
    .b_ready_o      (b_ready_o),
    .a_data_i       (a_data_i),
    .b_data_i       (b_data_i),
    .pair_valid_o   (pair_valid_o),
    .pair_data_o    (pair_data_o),
    .done_o         (done_o),
    .mac_data_i     (mac_data_i),
`ifdef SPARSE_MAC_SCHED_STATS_EN
    .stat_matches_o (stat_matches_o),
    .stat_cycles_o  (stat_cycles_o),
`endif
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_data_o  (result_data_o)
  );

  initial begin
    mac_clk = 1'b0;
    forever #5 mac_clk = ~mac_clk;
  end

  // multiply_and_accum model: product stage, then accumulate stage, no clear
  logic               prod_v;
  logic [ACCUM_W-1:0] prod, acc;
  always @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      prod_v <= 1'b0;
      prod   <= '0;
      acc    <= '0;
    end else begin
      prod_v <= pair_valid_o;
      prod   <= 32'(pair_data_o[0]) * 32'(pair_data_o[1]);
      if (prod_v) acc <= acc + prod;
    end
  end
  assign mac_data_i = acc;

  int           n_checks = 0;
  int           n_errors = 0;
  sparse_elem_t ja[$], jb[$], qa[$], qb[$];
  logic [31:0]  exp_pairs[$];
  logic [31:0]  exp_res[$];
  int           pair_cycles[$];
  int           pop_cnt_a = 0, pop_cnt_b = 0, done_cnt = 0, cyc = 0;
  bit           bubbles = 0;
  int           cur_matches, d0, pa0, pb0, pn0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stream sources: sample ready mid-cycle, retire the head after the edge
  initial begin : stream_driver
    bit ra, rb;
    a_valid_i = 1'b0; b_valid_i = 1'b0; a_data_i = '0; b_data_i = '0;
    forever begin
      @(negedge mac_clk);
      ra = a_ready_o && a_valid_i;
      rb = b_ready_o && b_valid_i;
      @(posedge mac_clk);
      #1;
      if (ra && qa.size() > 0) begin void'(qa.pop_front()); pop_cnt_a++; end
      if (rb && qb.size() > 0) begin void'(qb.pop_front()); pop_cnt_b++; end
      a_valid_i = (qa.size() > 0) && (!bubbles || $urandom_range(0, 3) != 0);
      b_valid_i = (qb.size() > 0) && (!bubbles || $urandom_range(0, 3) != 0);
      a_data_i  = (qa.size() > 0) ? qa[0] : '0;
      b_data_i  = (qb.size() > 0) ? qb[0] : '0;
    end
  end

  // Output monitor: pairs against the scoreboard, done pulse counting
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge mac_clk);
      cyc++;
      if (mac_rst) begin
        if (done_o) done_cnt++;
        if (pair_valid_o) begin
          pair_cycles.push_back(cyc);
          if (exp_pairs.size() == 0) check_value("pair_extra", 64'(1), 64'(0));
          else begin
            e = exp_pairs.pop_front();
            check_value("pair_data", 64'(pair_data_o), 64'(e));
          end
        end
      end
    end
  end

  task automatic clear_job();
    ja.delete();
    jb.delete();
  endtask

  task automatic add_a(input int idx, input int val);
    sparse_elem_t e;
    e.index = 16'(idx); e.value = 16'(val);
    ja.push_back(e);
  endtask

  task automatic add_b(input int idx, input int val);
    sparse_elem_t e;
    e.index = 16'(idx); e.value = 16'(val);
    jb.push_back(e);
  endtask

  task automatic gen_random_job();
    int la, lb;
    int idx;
    clear_job();
    la = $urandom_range(1, 6);
    lb = $urandom_range(1, 6);
    idx = $urandom_range(0, 2);
    for (int i = 0; i < la; i++) begin
      add_a(idx, $urandom_range(0, 255));
      idx += $urandom_range(1, 3);
    end
    idx = $urandom_range(0, 2);
    for (int i = 0; i < lb; i++) begin
      add_b(idx, $urandom_range(0, 255));
      idx += $urandom_range(1, 3);
    end
  endtask

  task automatic start_job(input string name);
    logic [31:0] sum;
    int t;
    sum = '0;
    cur_matches = 0;
    foreach (ja[i]) foreach (jb[j]) begin
      if (ja[i].index == jb[j].index) begin
        exp_pairs.push_back({jb[j].value, ja[i].value});
        sum += 32'(ja[i].value) * 32'(jb[j].value);
        cur_matches++;
      end
    end
    exp_res.push_back(sum);
    @(negedge mac_clk);
    d0 = done_cnt; pa0 = pop_cnt_a; pb0 = pop_cnt_b; pn0 = pair_cycles.size();
    qa = ja;
    qb = jb;
    job_len_a_i = 16'(ja.size());
    job_len_b_i = 16'(jb.size());
    t = 0;
    while (!job_ready_o && t < 100) begin @(negedge mac_clk); t++; end
    check_value({name, "_job_ready"}, 64'(job_ready_o), 64'(1));
    job_valid_i = 1'b1;
    @(posedge mac_clk);
    #1 job_valid_i = 1'b0;
  endtask

  task automatic finish_job(input string name, input int hold);
    logic [31:0] e;
    int t;
    t = 0;
    while (!result_valid_o && t < 500) begin @(negedge mac_clk); t++; end
    check_value({name, "_result_valid"}, 64'(result_valid_o), 64'(1));
    e = (exp_res.size() > 0) ? exp_res.pop_front() : 32'hDEAD_BEEF;
    check_value({name, "_result"}, 64'(result_data_o), 64'(e));
    for (int k = 0; k < hold; k++) begin
      @(negedge mac_clk);
      check_value({name, "_hold_valid"}, 64'(result_valid_o), 64'(1));
      check_value({name, "_hold_data"}, 64'(result_data_o), 64'(e));
      check_value({name, "_hold_job_ready"}, 64'(job_ready_o), 64'(0));
    end
    result_ready_i = 1'b1;
    @(posedge mac_clk);
    #1 result_ready_i = 1'b0;
    @(negedge mac_clk);
    check_value({name, "_result_cleared"}, 64'(result_valid_o), 64'(0));
    check_value({name, "_idle_ready"}, 64'(job_ready_o), 64'(1));
    check_value({name, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    check_value({name, "_pops_a"}, 64'(pop_cnt_a - pa0), 64'(ja.size()));
    check_value({name, "_pops_b"}, 64'(pop_cnt_b - pb0), 64'(jb.size()));
    check_value({name, "_pair_count"}, 64'(pair_cycles.size() - pn0), 64'(cur_matches));
    check_value({name, "_pairs_left"}, 64'(exp_pairs.size()), 64'(0));
`ifdef SPARSE_MAC_SCHED_STATS_EN
    check_value({name, "_stat_matches"}, 64'(stat_matches_o), 64'(cur_matches));
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    mac_rst = 1'b0;
    job_valid_i = 1'b0;
    job_len_a_i = '0;
    job_len_b_i = '0;
    result_ready_i = 1'b0;
    repeat (3) @(negedge mac_clk);
    check_value("rst_job_ready", 64'(job_ready_o), 64'(0));
    check_value("rst_pair_valid", 64'(pair_valid_o), 64'(0));
    check_value("rst_done", 64'(done_o), 64'(0));
    check_value("rst_result_valid", 64'(result_valid_o), 64'(0));
    check_value("rst_result_data", 64'(result_data_o), 64'(0));
    mac_rst = 1'b1;
    @(negedge mac_clk);
    check_value("post_rst_job_ready", 64'(job_ready_o), 64'(1));

    // Basic match: 4*10 + 6*1
    clear_job();
    add_a(1, 2); add_a(3, 4); add_a(5, 6);
    add_b(3, 10); add_b(5, 1); add_b(7, 9);
    start_job("basic");
    finish_job("basic", 0);

    // Base subtraction: accumulator now 46, single match 7*3
    clear_job();
    add_a(4, 7); add_b(4, 3);
    start_job("base");
    finish_job("base", 0);
    check_value("base_mac_acc", 64'(acc), 64'(67));

    // Disjoint indices with stream bubbles
    bubbles = 1;
    clear_job();
    add_a(0, 5); add_a(2, 6);
    add_b(1, 7); add_b(3, 8);
    start_job("disjoint");
    finish_job("disjoint", 0);

    // Zero-length A: all of B drained in FLUSH
    clear_job();
    add_b(1, 3); add_b(2, 4); add_b(9, 5);
    start_job("zero_len");
    finish_job("zero_len", 0);

    // Result backpressure for 5 cycles
    clear_job();
    add_a(0, 9); add_a(8, 2);
    add_b(8, 5);
    start_job("backpressure");
    finish_job("backpressure", 5);

    // Back-to-back matches, simultaneous last pop
    bubbles = 0;
    clear_job();
    add_a(1, 1); add_a(2, 2); add_a(3, 3);
    add_b(1, 4); add_b(2, 5); add_b(3, 6);
    start_job("b2b");
    finish_job("b2b", 0);
    if (pair_cycles.size() >= pn0 + 3)
      check_value("b2b_consecutive", 64'(pair_cycles[pn0 + 2] - pair_cycles[pn0]), 64'(2));
    else
      check_value("b2b_pairs_seen", 64'(pair_cycles.size() - pn0), 64'(3));

    // Random jobs with bubbles
    bubbles = 1;
    for (int r = 0; r < 6; r++) begin
      gen_random_job();
      start_job("random");
      finish_job("random", $urandom_range(0, 2));
    end

    // Reset mid-MERGE after the first pair
    bubbles = 0;
    clear_job();
    add_a(1, 1); add_a(2, 2); add_a(3, 3);
    add_b(1, 4); add_b(2, 5); add_b(3, 6);
    start_job("midrst");
    t = 0;
    while (!pair_valid_o && t < 50) begin @(negedge mac_clk); t++; end
    check_value("midrst_first_pair", 64'(pair_valid_o), 64'(1));
    #2 mac_rst = 1'b0;
    #1;
    check_value("midrst_job_ready", 64'(job_ready_o), 64'(0));
    check_value("midrst_pair_valid", 64'(pair_valid_o), 64'(0));
    check_value("midrst_pair_data", 64'(pair_data_o), 64'(0));
    check_value("midrst_a_ready", 64'(a_ready_o), 64'(0));
    check_value("midrst_b_ready", 64'(b_ready_o), 64'(0));
    check_value("midrst_done", 64'(done_o), 64'(0));
    check_value("midrst_result_valid", 64'(result_valid_o), 64'(0));
    check_value("midrst_result_data", 64'(result_data_o), 64'(0));
    repeat (2) @(negedge mac_clk);
    qa.delete();
    qb.delete();
    exp_pairs.delete();
    exp_res.delete();
    @(negedge mac_clk);
    mac_rst = 1'b1;
    @(negedge mac_clk);
    check_value("midrst_ready_after", 64'(job_ready_o), 64'(1));
    clear_job();
    add_a(2, 5); add_b(2, 6);
    start_job("after_rst");
    finish_job("after_rst", 0);

    repeat (3) @(negedge mac_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
